// File: rtl/smps_sense_adc_reader.sv
// DRDY-triggered SPI reader for the 24-bit SMPS sense ADC, alternating voltage/current via ADC_CH.
// Optional 4-frame averaging per channel when SENSE_AVG_EN is defined.
module smps_sense_adc_reader #(
  parameter int CLK_DIV     = 10,
  parameter int CS_SETUP    = 4,
  parameter int MUX_SETTLE  = 200,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ADC_DRDY_n,
  input  logic        ADC_DOUT,
  output logic        ADC_CS_n,
  output logic        ADC_SCLK,
  output logic        ADC_CH,
  output logic [23:0] SMPS_50V_VSense,
  output logic [23:0] SMPS_50V_CSense,
  output logic        vsense_valid,
  output logic        csense_valid,
  output logic        sense_timeout
);

  localparam logic [31:0] SETUP_LAST   = 32'(CS_SETUP - 1);
  localparam logic [31:0] DIV_LAST     = 32'(CLK_DIV - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(MUX_SETTLE - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, SETTLE} state_t;

  state_t      state, state_next;
  logic        drdy_s1, drdy_s2, drdy_prev, drdy_fall;
  logic [31:0] cnt, to_cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] shift_reg;
  logic        cnt_clr, start_frame, sclk_rise, sclk_fall, frame_done;

  // Synchronizer resets high so a DRDY already idle-high never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drdy_s1   <= 1'b1;
      drdy_s2   <= 1'b1;
      drdy_prev <= 1'b1;
    end else begin
      drdy_s1   <= ADC_DRDY_n;
      drdy_s2   <= drdy_s1;
      drdy_prev <= drdy_s2;
    end
  end

  assign drdy_fall = drdy_prev & ~drdy_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    start_frame = 1'b0;
    sclk_rise   = 1'b0;
    sclk_fall   = 1'b0;
    frame_done  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (drdy_fall) begin
          state_next  = SETUP;
          start_frame = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_next = SHIFT;
          cnt_clr    = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_clr = 1'b1;
          if (!ADC_SCLK) begin
            sclk_rise = 1'b1;
          end else begin
            sclk_fall = 1'b1;
            if (bit_cnt == 5'd23) state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = SETTLE;
        frame_done = 1'b1;
        cnt_clr    = 1'b1;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // DOUT is captured on the same clk edge that raises SCLK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      ADC_CS_n  <= 1'b1;
      ADC_SCLK  <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 32'd1;
      if (start_frame) begin
        ADC_CS_n <= 1'b0;
        bit_cnt  <= '0;
      end
      if (sclk_rise) begin
        ADC_SCLK  <= 1'b1;
        shift_reg <= {shift_reg[22:0], ADC_DOUT};
      end
      if (sclk_fall) begin
        ADC_SCLK <= 1'b0;
        bit_cnt  <= bit_cnt + 5'd1;
      end
      if (frame_done) ADC_CS_n <= 1'b1;
    end
  end

`ifdef SENSE_AVG_EN
  logic [25:0] acc_v, acc_c, acc_sum;
  logic [1:0]  fcnt_v, fcnt_c;

  assign acc_sum = (ADC_CH ? acc_c : acc_v) + {2'b00, shift_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SMPS_50V_VSense <= '0;
      SMPS_50V_CSense <= '0;
      vsense_valid    <= 1'b0;
      csense_valid    <= 1'b0;
      ADC_CH          <= 1'b0;
      acc_v           <= '0;
      acc_c           <= '0;
      fcnt_v          <= '0;
      fcnt_c          <= '0;
    end else begin
      vsense_valid <= 1'b0;
      csense_valid <= 1'b0;
      if (frame_done) begin
        ADC_CH <= ~ADC_CH;
        if (!ADC_CH) begin
          fcnt_v <= fcnt_v + 2'd1;
          if (fcnt_v == 2'd3) begin
            SMPS_50V_VSense <= acc_sum[25:2];
            vsense_valid    <= 1'b1;
            acc_v           <= '0;
          end else begin
            acc_v <= acc_sum;
          end
        end else begin
          fcnt_c <= fcnt_c + 2'd1;
          if (fcnt_c == 2'd3) begin
            SMPS_50V_CSense <= acc_sum[25:2];
            csense_valid    <= 1'b1;
            acc_c           <= '0;
          end else begin
            acc_c <= acc_sum;
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SMPS_50V_VSense <= '0;
      SMPS_50V_CSense <= '0;
      vsense_valid    <= 1'b0;
      csense_valid    <= 1'b0;
      ADC_CH          <= 1'b0;
    end else begin
      vsense_valid <= 1'b0;
      csense_valid <= 1'b0;
      if (frame_done) begin
        ADC_CH <= ~ADC_CH;
        if (!ADC_CH) begin
          SMPS_50V_VSense <= shift_reg;
          vsense_valid    <= 1'b1;
        end else begin
          SMPS_50V_CSense <= shift_reg;
          csense_valid    <= 1'b1;
        end
      end
    end
  end
`endif

  // A frame start wins over a coincident expiry; the counter saturates once the flag is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt        <= '0;
      sense_timeout <= 1'b0;
    end else if (start_frame) begin
      to_cnt <= '0;
    end else if (frame_done) begin
      sense_timeout <= 1'b0;
    end else if (state == IDLE) begin
      if (to_cnt == TIMEOUT_LAST) sense_timeout <= 1'b1;
      else                        to_cnt        <= to_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_smps_sense_adc_reader.sv
// Self-checking bench for smps_sense_adc_reader: frame-level reference model checked every cycle,
// plus directed literal checks on words, latency, DRDY handling, mid-frame reset and timeout.
module tb_smps_sense_adc_reader;

  localparam int CLK_DIV     = 10;
  localparam int CS_SETUP    = 4;
  localparam int MUX_SETTLE  = 200;
  localparam int TIMEOUT_CYC = 3000;
  localparam int SYNC        = 3;
  localparam int FRAME       = CS_SETUP + 48 * CLK_DIV + 1;
  localparam int FIRST_RISE  = SYNC + CS_SETUP + CLK_DIV;
  localparam int DONE_AT     = SYNC + FRAME;
  localparam int IDLE_AT     = DONE_AT + MUX_SETTLE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_drdy_n = 1'b1;
  logic        adc_dout = 1'b0;
  logic        ADC_CS_n, ADC_SCLK, ADC_CH;
  logic [23:0] SMPS_50V_VSense, SMPS_50V_CSense;
  logic        vsense_valid, csense_valid, sense_timeout;

  smps_sense_adc_reader #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .MUX_SETTLE(MUX_SETTLE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .ADC_DRDY_n(adc_drdy_n), .ADC_DOUT(adc_dout),
    .ADC_CS_n(ADC_CS_n), .ADC_SCLK(ADC_SCLK), .ADC_CH(ADC_CH),
    .SMPS_50V_VSense(SMPS_50V_VSense), .SMPS_50V_CSense(SMPS_50V_CSense),
    .vsense_valid(vsense_valid), .csense_valid(csense_valid), .sense_timeout(sense_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one frame in flight, described by the posedge index its DRDY fell on.
  int          m_p = -1;
  logic [23:0] m_word;
  logic [23:0] exp_v, exp_c;
  logic        exp_ch;
  logic [25:0] m_acc [2];
  int          m_n   [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic modelReset();
    m_p    = -1;
    exp_v  = '0;
    exp_c  = '0;
    exp_ch = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = '0;
      m_n[i]   = 0;
    end
  endtask

  // Per-cycle compare against the model.
  int   rel;
  logic exp_cs, exp_sclk, exp_vv, exp_cv;
  always @(negedge clk) begin
    if (!rst) begin
      rel    = cyc - m_p;
      exp_vv = 1'b0;
      exp_cv = 1'b0;
      if (m_p >= 0 && rel == DONE_AT) begin
`ifdef SENSE_AVG_EN
        m_acc[exp_ch] = m_acc[exp_ch] + {2'b00, m_word};
        m_n[exp_ch]++;
        if (m_n[exp_ch] == 4) begin
          if (!exp_ch) begin exp_v = 24'(m_acc[0] / 4); exp_vv = 1'b1; end
          else         begin exp_c = 24'(m_acc[1] / 4); exp_cv = 1'b1; end
          m_acc[exp_ch] = '0;
          m_n[exp_ch]   = 0;
        end
`else
        if (!exp_ch) begin exp_v = m_word; exp_vv = 1'b1; end
        else         begin exp_c = m_word; exp_cv = 1'b1; end
`endif
        exp_ch = ~exp_ch;
      end
      exp_cs   = !(m_p >= 0 && rel >= SYNC && rel < DONE_AT);
      exp_sclk = (m_p >= 0 && rel >= FIRST_RISE && rel < FIRST_RISE + 48 * CLK_DIV &&
                  ((rel - FIRST_RISE) % (2 * CLK_DIV)) < CLK_DIV);
      checkOutput("cyc_cs_n",    32'(ADC_CS_n),        32'(exp_cs));
      checkOutput("cyc_sclk",    32'(ADC_SCLK),        32'(exp_sclk));
      checkOutput("cyc_ch",      32'(ADC_CH),          32'(exp_ch));
      checkOutput("cyc_vsense",  32'(SMPS_50V_VSense), 32'(exp_v));
      checkOutput("cyc_csense",  32'(SMPS_50V_CSense), 32'(exp_c));
      checkOutput("cyc_vvalid",  32'(vsense_valid),    32'(exp_vv));
      checkOutput("cyc_cvalid",  32'(csense_valid),    32'(exp_cv));
    end
  end

  // Event monitor for latency and frame/strobe counting.
  logic prev_cs = 1'b1;
  int   cs_fall_cyc = 0, valid_cyc = 0, n_frames = 0, n_vstrobe = 0, n_cstrobe = 0;
  always @(negedge clk) begin
    if (prev_cs && !ADC_CS_n) begin
      cs_fall_cyc = cyc;
      n_frames++;
    end
    prev_cs = ADC_CS_n;
    if (vsense_valid) begin valid_cyc = cyc; n_vstrobe++; end
    if (csense_valid) begin valid_cyc = cyc; n_cstrobe++; end
  end

  // Drops DRDY, plays the ADC serializer from its own timeline, optional DRDY glitch / reset abort.
  task automatic applyStimulus(input logic [23:0] word, input int low_len, input int pulse_at,
                               input int abort_at);
    int len;
    int b;
    len = (low_len > IDLE_AT + 12) ? low_len : IDLE_AT + 12;
    @(posedge clk); #1;
    m_p        = cyc;
    m_word     = word;
    adc_drdy_n = 1'b0;
    adc_dout   = word[23];
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (k == low_len) adc_drdy_n = 1'b1;
      if (pulse_at != 0 && k == pulse_at) adc_drdy_n = 1'b0;
      if (pulse_at != 0 && k == pulse_at + 4) adc_drdy_n = 1'b1;
      if (k >= FIRST_RISE + CLK_DIV && ((k - FIRST_RISE - CLK_DIV) % (2 * CLK_DIV)) == 0) begin
        b = (k - FIRST_RISE - CLK_DIV) / (2 * CLK_DIV) + 1;
        if (b < 24) adc_dout = word[23 - b];
      end
      if (abort_at != 0 && k == abort_at) begin
        checkOutput("pre_reset_sclk_high", 32'(ADC_SCLK), 32'd1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("reset_cs_n",   32'(ADC_CS_n),        32'd1);
        checkOutput("reset_sclk",   32'(ADC_SCLK),        32'd0);
        checkOutput("reset_vsense", 32'(SMPS_50V_VSense), 32'd0);
        checkOutput("reset_csense", 32'(SMPS_50V_CSense), 32'd0);
        checkOutput("reset_ch",     32'(ADC_CH),          32'd0);
        adc_drdy_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
    end
  endtask

  int f0;

  initial begin
    modelReset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs_n",    32'(ADC_CS_n),        32'd1);
    checkOutput("rst_sclk",    32'(ADC_SCLK),        32'd0);
    checkOutput("rst_ch",      32'(ADC_CH),          32'd0);
    checkOutput("rst_vsense",  32'(SMPS_50V_VSense), 32'd0);
    checkOutput("rst_csense",  32'(SMPS_50V_CSense), 32'd0);
    checkOutput("rst_valids",  32'({vsense_valid, csense_valid}), 32'd0);
    checkOutput("rst_timeout", 32'(sense_timeout),   32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

`ifdef SENSE_AVG_EN
    applyStimulus(24'd100, 20, 0, 0);
    applyStimulus(24'd7,   20, 0, 0);
    applyStimulus(24'd101, 20, 0, 0);
    applyStimulus(24'd8,   20, 0, 0);
    applyStimulus(24'd102, 20, 0, 0);
    applyStimulus(24'd9,   20, 0, 0);
    checkOutput("avg_no_vstrobe_3", 32'(n_vstrobe), 32'd0);
    checkOutput("avg_vsense_hold",  32'(SMPS_50V_VSense), 32'd0);
    applyStimulus(24'd104, 20, 0, 0);
    checkOutput("avg_vsense",       32'(SMPS_50V_VSense), 32'd101);
    checkOutput("avg_vstrobe_once", 32'(n_vstrobe), 32'd1);
    applyStimulus(24'd10,  20, 0, 0);
    checkOutput("avg_csense",       32'(SMPS_50V_CSense), 32'd8);
    checkOutput("avg_cstrobe_once", 32'(n_cstrobe), 32'd1);
`else
    applyStimulus(24'h0BDC00, 20, 0, 0);
    checkOutput("f1_vsense",  32'(SMPS_50V_VSense), 32'h0BDC00);
    checkOutput("f1_csense",  32'(SMPS_50V_CSense), 32'h0);
    checkOutput("f1_ch",      32'(ADC_CH),          32'd1);
    checkOutput("f1_latency", 32'(valid_cyc - cs_fall_cyc), 32'd485);
    checkOutput("f1_strobe",  32'(n_vstrobe),       32'd1);

    applyStimulus(24'hB3B5C0, 20, 0, 0);
    checkOutput("f2_csense",  32'(SMPS_50V_CSense), 32'hB3B5C0);
    checkOutput("f2_vsense",  32'(SMPS_50V_VSense), 32'h0BDC00);
    checkOutput("f2_ch",      32'(ADC_CH),          32'd0);
    checkOutput("f2_strobe",  32'(n_cstrobe),       32'd1);

    f0 = n_frames;
    applyStimulus(24'h123456, 2000, 0, 0);
    checkOutput("hold_low_frames", 32'(n_frames - f0), 32'd1);
    checkOutput("hold_low_vsense", 32'(SMPS_50V_VSense), 32'h123456);

    f0 = n_frames;
    applyStimulus(24'hA5A5A5, 20, 200, 0);
    checkOutput("glitch_frames", 32'(n_frames - f0),    32'd1);
    checkOutput("glitch_csense", 32'(SMPS_50V_CSense), 32'hA5A5A5);

    applyStimulus(24'hFFFFFF, 20, 0, FIRST_RISE + 12 * 2 * CLK_DIV + 3);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(24'h00F00D, 20, 0, 0);
    checkOutput("post_reset_vsense", 32'(SMPS_50V_VSense), 32'h00F00D);
    checkOutput("post_reset_csense", 32'(SMPS_50V_CSense), 32'h0);
    checkOutput("post_reset_ch",     32'(ADC_CH),          32'd1);

    repeat (TIMEOUT_CYC - 100) @(posedge clk);
    #1;
    checkOutput("timeout_early", 32'(sense_timeout), 32'd0);
    repeat (200) @(posedge clk);
    #1;
    checkOutput("timeout_set",   32'(sense_timeout), 32'd1);
    applyStimulus(24'h000001, 20, 0, 0);
    checkOutput("timeout_clear", 32'(sense_timeout), 32'd0);
    checkOutput("timeout_csense", 32'(SMPS_50V_CSense), 32'h000001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
